// File: rtl/unread_observer.sv
// Snapshots a vector of otherwise-unread nets and streams it out in CHUNK-sized beats
// over valid/ready, alongside a registered XOR signature so no input bit is pruned.
module unread_observer #(
  parameter  int WIDTH      = 32,
  parameter  int CHUNK      = 8,
  localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             busy_o,
  output logic             obs_valid_o,
  input  logic             obs_ready_i,
  output logic [CHUNK-1:0] obs_data_o,
  output logic [IDX_W-1:0] obs_idx_o,
  output logic             obs_last_o,
  output logic             sig_o,
  output logic [7:0]       frame_cnt_o
);

  localparam int TOTAL = NUM_CHUNKS * CHUNK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                           state_q;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] snap_q;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] snap_d;
  logic [IDX_W-1:0]                 idx_q;
  logic                             sig_q;
  logic [7:0]                       frame_cnt_q;
  logic [CHUNK-1:0]                 data_d;

  // The snapshot is padded with zeros up to a whole number of chunks.
  always_comb begin
    snap_d = TOTAL'(d_i);
  end

  always_comb begin
    data_d = '0;
    if (state_q == SEND) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        if (idx_q == IDX_W'(k)) data_d = snap_q[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      sig_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      sig_q <= ^d_i;
      unique case (state_q)
        IDLE: begin
          if (en_i) begin
            snap_q  <= snap_d;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (obs_ready_i) begin
            if (idx_q == LAST_IDX) begin
              // Index returns to 0 so the idle idx output looks like reset.
              idx_q       <= '0;
              state_q     <= IDLE;
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == SEND);
  assign obs_valid_o = (state_q == SEND);
  assign obs_data_o  = data_d;
  assign obs_idx_o   = idx_q;
  assign obs_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign sig_o       = sig_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_unread_observer.sv
// Directed bench for unread_observer: a 20-bit/8-bit instance for framing, backpressure,
// wrap and reset behaviour, plus an 8-bit/8-bit instance for the single-beat frame case.
module tb_unread_observer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [19:0] d;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [7:0]  data;
  logic [1:0]  idx;
  logic        last;
  logic        sig;
  logic [7:0]  fcnt;

  logic        en2;
  logic [7:0]  d2;
  logic        busy2;
  logic        valid2;
  logic [7:0]  data2;
  logic [0:0]  idx2;
  logic        last2;
  logic        sig2;
  logic [7:0]  fcnt2;

  int tests;
  int fails;

  unread_observer #(.WIDTH(20), .CHUNK(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .busy_o(busy),
    .obs_valid_o(valid), .obs_ready_i(ready), .obs_data_o(data),
    .obs_idx_o(idx), .obs_last_o(last), .sig_o(sig), .frame_cnt_o(fcnt)
  );

  unread_observer #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en2), .d_i(d2), .busy_o(busy2),
    .obs_valid_o(valid2), .obs_ready_i(ready), .obs_data_o(data2),
    .obs_idx_o(idx2), .obs_last_o(last2), .sig_o(sig2), .frame_cnt_o(fcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en2 = 1'b0; ready = 1'b0; d = '0; d2 = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    tests++;
    if ({valid, busy, fcnt, sig} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_idle got v=%b b=%b cnt=%0d sig=%b want 0 0 0 0", valid, busy, fcnt, sig);
    end
    tests++;
    if ({data, idx, last} !== {8'h00, 2'd0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_obs got data=%h idx=%0d last=%b want 00 0 0", data, idx, last);
    end
    tests++;
    if ({valid2, busy2, fcnt2, last2} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_dut1 got v=%b b=%b cnt=%0d last=%b want 0 0 0 0", valid2, busy2, fcnt2, last2);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_data [3];
    exp_data[0] = 8'hDE; exp_data[1] = 8'hBC; exp_data[2] = 8'h0A;
    d = 20'hABCDE; en = 1'b1; ready = 1'b1;
    tick();
    en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tests++;
      if ({valid, busy, data, idx, last} !== {1'b1, 1'b1, exp_data[b], 2'(b), (b == 2)}) begin
        fails++;
        $display("[TB] FAIL basic_beat%0d got v=%b b=%b data=%h idx=%0d last=%b want 1 1 %h %0d %b",
                 b, valid, busy, data, idx, last, exp_data[b], b, (b == 2));
      end
      tick();
    end
    tests++;
    if ({valid, busy, fcnt} !== {1'b0, 1'b0, 8'd1}) begin
      fails++;
      $display("[TB] FAIL basic_end got v=%b b=%b cnt=%0d want 0 0 1", valid, busy, fcnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_data [3];
    int hs;
    exp_data[0] = 8'hDE; exp_data[1] = 8'hBC; exp_data[2] = 8'h0A;
    hs = 0;
    d = 20'hABCDE; en = 1'b1; ready = 1'b0;
    tick();
    en = 1'b0;
    d = 20'h12345;
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 3; s++) begin
        tests++;
        if ({valid, data, idx} !== {1'b1, exp_data[b], 2'(b)}) begin
          fails++;
          $display("[TB] FAIL bp_stall%0d_%0d got v=%b data=%h idx=%0d want 1 %h %0d",
                   b, s, valid, data, idx, exp_data[b], b);
        end
        tick();
      end
      ready = 1'b1;
      if (valid) hs++;
      tick();
      ready = 1'b0;
    end
    tests++;
    if ({valid, fcnt} !== {1'b0, 8'd2} || hs != 3) begin
      fails++;
      $display("[TB] FAIL bp_end got v=%b cnt=%0d hs=%0d want 0 2 3", valid, fcnt, hs);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d = 20'hABCDE; en = 1'b1; ready = 1'b1;
    bad = 0;
    for (int f = 0; f < 256; f++) begin
      tick();
      for (int b = 0; b < 3; b++) begin
        if (!(valid === 1'b1 && idx === 2'(b))) bad++;
        if (b == 0 && data !== 8'hDE) bad++;
        if (b < 2) tick();
      end
      if (f == 255) en = 1'b0;
      tick();
      if (valid !== 1'b0) bad++;
      if (f == 254) begin
        tests++;
        if (fcnt !== 8'd255) begin
          fails++;
          $display("[TB] FAIL b2b_cnt255 got cnt=%0d want 255", fcnt);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL b2b_pattern got %0d bad cycles want 0", bad);
    end
    tests++;
    if (fcnt !== 8'd0) begin
      fails++;
      $display("[TB] FAIL b2b_wrap got cnt=%0d want 0", fcnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    d = 20'hABCDE; en = 1'b1; ready = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tests++;
    if ({valid, idx} !== {1'b1, 2'd1}) begin
      fails++;
      $display("[TB] FAIL mid_pre got v=%b idx=%0d want 1 1", valid, idx);
    end
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    tests++;
    if ({valid, busy, idx, fcnt, data, sig} !== {1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 1'b0}) begin
      fails++;
      $display("[TB] FAIL mid_reset got v=%b b=%b idx=%0d cnt=%0d data=%h sig=%b want 0 0 0 0 00 0",
               valid, busy, idx, fcnt, data, sig);
    end
    d = 20'h12345; en = 1'b1;
    tick();
    en = 1'b0;
    tests++;
    if ({valid, data, idx} !== {1'b1, 8'h45, 2'd0}) begin
      fails++;
      $display("[TB] FAIL mid_restart got v=%b data=%h idx=%0d want 1 45 0", valid, data, idx);
    end
    repeat (3) tick();
    tests++;
    if ({valid, fcnt} !== {1'b0, 8'd1}) begin
      fails++;
      $display("[TB] FAIL mid_finish got v=%b cnt=%0d want 0 1", valid, fcnt);
    end
  endtask

  task automatic test_signature();
    logic [19:0] seq [4];
    logic        exp_sig [4];
    seq[0] = 20'h0; seq[1] = 20'h1; seq[2] = 20'h3; seq[3] = 20'h7;
    exp_sig[0] = 1'b0; exp_sig[1] = 1'b1; exp_sig[2] = 1'b0; exp_sig[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = seq[i];
      tick();
      tests++;
      if (sig !== exp_sig[i]) begin
        fails++;
        $display("[TB] FAIL sig_%0d got %b want %b", i, sig, exp_sig[i]);
      end
    end
  endtask

  task automatic test_single_beat();
    d2 = 8'hA5; en2 = 1'b1; ready = 1'b1;
    tick();
    en2 = 1'b0;
    tests++;
    if ({valid2, data2, idx2, last2} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL single_beat got v=%b data=%h idx=%0d last=%b want 1 a5 0 1",
               valid2, data2, idx2, last2);
    end
    tick();
    tests++;
    if ({valid2, fcnt2, sig2} !== {1'b0, 8'd1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL single_end got v=%b cnt=%0d sig=%b want 0 1 0", valid2, fcnt2, sig2);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_signature();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
